alu_muldiv: RTL

- Parametrised successor to the single-cycle datapath ALU.
- Keeps the AND/OR/ADD/SUB/SLT function codes and adds signed and unsigned multiply and divide, HI/LO registers and MFHI/MFLO.
- Uses a valid/ready issue handshake, so the pipeline stalls the EX stage while an iterative multiply or divide is in flight.
- Sits in EX; the hazard unit stalls on `in_ready` low.

---
 rtl/alu_muldiv.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// EX-stage ALU with single-cycle logic/arithmetic ops plus iterative signed/unsigned
// multiply and divide writing HI/LO, issued through a valid/ready handshake.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, neg_q, rem_neg_q, dz_q;
  logic [WIDTH-1:0]   a_q, mb_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q;
  logic               zero_q, ovf_q, dbz_q;

  logic accept, is_md, signed_op, sa, sb;
  logic [WIDTH-1:0] ma, mb;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_RESP);
  assign accept    = in_valid && in_ready && !flush;
  assign is_md     = (alu_ctrl[3:2] == 2'b10);
  assign signed_op = ~alu_ctrl[0];
  assign sa        = signed_op & op_a[WIDTH-1];
  assign sb        = signed_op & op_b[WIDTH-1];
  assign ma        = sa ? -op_a : op_a;
  assign mb        = sb ? -op_b : op_b;

  // Single-cycle function unit, evaluated on the operands at the accept edge.
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // prod_q is {upper, lower}: product accumulator/multiplier, or remainder/quotient.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;

  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mb_q : '0)};
  assign mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mb_q});
  assign div_sub   = div_shift[WIDTH-1:0] - mb_q;
  assign div_next  = div_ge ? {div_sub, prod_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
  assign prod_neg  = -prod_q;

  logic [WIDTH-1:0] fix_hi, fix_lo;
  always_comb begin
    fix_hi = prod_q[2*WIDTH-1:WIDTH];
    fix_lo = prod_q[WIDTH-1:0];
    if (dz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else if (is_div_q) begin
      if (neg_q)     fix_lo = -prod_q[WIDTH-1:0];
      if (rem_neg_q) fix_hi = -prod_q[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = is_md ? S_ITER : S_RESP;
        cnt_d   = '0;
      end
      S_ITER: begin
        if (flush)                   state_d = S_IDLE;
        else if (cnt_q == LAST_ITER) state_d = S_FIX;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      S_FIX:   state_d = flush ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= '0;
      mb_q      <= '0;
      prod_q    <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        ovf_q     <= alu_ovf;
        dbz_q     <= 1'b0;
        is_div_q  <= alu_ctrl[1];
        neg_q     <= sa ^ sb;
        rem_neg_q <= sa;
        dz_q      <= alu_ctrl[1] && (op_b == '0);
        a_q       <= op_a;
        mb_q      <= mb;
        prod_q    <= {{WIDTH{1'b0}}, ma};
        if (!is_md) begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
        end
      end
      if (state_q == S_ITER && !flush) begin
        prod_q <= is_div_q ? div_next : mul_next;
      end
      if (state_q == S_FIX && !flush) begin
        hi_q     <= fix_hi;
        lo_q     <= fix_lo;
        result_q <= fix_lo;
        zero_q   <= (fix_lo == '0);
        dbz_q    <= dz_q;
      end
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
